uart_rx_mmio: RTL and testbench
===============================

// Module: uart_rx_mmio
// PURPOSE
//  Serial UART receiver (8N1, optional parity) with a receive FIFO.
//  Exposed to the core as a memory-mapped read-side peripheral next to the TX
//  port at 0x1000, so software can poll and pop received bytes with plain loads.
//  Reception is async to software; bytes wait in the FIFO until read.
// PARAMETERS
//  CLK_DIV     16            clk cycles per bit; >=4, even
//  FIFO_DEPTH  8             entries; power of 2, 2..16
//  BASE_ADDR   32'h0000_1004 STATUS at BASE_ADDR, DATA at BASE_ADDR+4
// PORTS
//  clk      in   1   sole clock; one clock, reset is asynchronous and active-high
//  rst      in   1   async active-high reset
//  uart_rx  in   1   serial line, idle high, async to clk
//  rd_addr  in   32  load address from the core data read bus
//  rd_en    in   1   core performs a load this cycle (side effects qualify on it)
//  rd_data  out  32  combinational read data; 0 when rd_addr matches neither reg
//  rx_irq   out  1   registered; 1 while FIFO not empty
// BEHAVIOUR
//  Reset: FSM IDLE, FIFO empty, sticky flags 0, rx_irq 0, sync flops 1.
//  uart_rx passes a 2-flop synchronizer (reset to 1); FSM uses synced value.
//  FSM IDLE->START on synced falling edge; bit counter loads CLK_DIV/2-1.
//   START: at count 0 sample; low -> DATA (counter CLK_DIV-1), high -> IDLE (glitch).
//   DATA: sample every CLK_DIV cycles, 8 bits LSB first into shift reg.
//   PARITY (macro only): one more sample; even parity checked.
//   STOP: sample mid stop bit. High + no error -> push byte; low -> frame_err
//    set, byte dropped, go WAIT_IDLE; else -> IDLE same cycle (no extra wait).
//   WAIT_IDLE: stay until synced line high, then IDLE.
//  Push commits at the clk edge of the stop sample; visible next cycle.
//  Push when full: byte dropped, overrun set, FIFO unchanged — unless a pop
//   occurs the same cycle, then push is accepted (count stays FIFO_DEPTH).
//  STATUS [0] not_empty [1] overrun [2] frame_err [3] parity_err
//   [8+:5] count; other bits 0.
//  DATA [7:0] FIFO head byte, [31:8] 0; reads 0 when empty.
//  Pop: rd_en && rd_addr==DATA && not empty, at clk edge. Empty pop: no effect.
//  STATUS read with rd_en clears bits [3:1] at clk edge; a flag set in the
//   same cycle wins over the clear (stays 1).
//  Simultaneous push+pop on non-full FIFO: both occur, count unchanged.
//  Pointers wrap modulo FIFO_DEPTH; count is separate, 0..FIFO_DEPTH.
//  rx_irq = registered (count_next != 0).
//  Reset asserted mid-frame: frame discarded, FIFO flushed, FSM IDLE.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1; PARITY state present; parity
//   mismatch sets parity_err and drops the byte (stop bit still checked).
//  Not defined: 8N1, no PARITY state, STATUS[3] reads constant 0.
// STRUCTURE
//  Package uart_pkg: UART_TX_ADDR (32'h1000), STATUS/DATA offsets,
//   rx_state_t enum {IDLE,START,DATA,PARITY,STOP,WAIT_IDLE}, STATUS bit indices.
//  Sub-module uart_rx_fifo: sync FIFO, push/pop/full/empty/count, head data
//   combinational; push-when-full+pop handled inside. FSM + regs stay top-level.
// TESTING (CLK_DIV=16, FIFO_DEPTH=8)
//  Send 0xA5 8N1 -> ~154 cycles after start edge STATUS=0x0000_0101,
//   rx_irq=1; DATA load =0xA5; next STATUS=0x0000_0000, rx_irq=0.
//  Low pulse of 5 cycles on idle line -> FSM back to IDLE, no push,
//   STATUS=0.
//  Send 9 bytes 0x01..0x09 without reading -> STATUS=0x0000_0803 (count 8,
//   overrun); pops return 0x01..0x08; STATUS read clears bit1.
//  Stop bit held low on 0x3C -> STATUS=0x0000_0004, FIFO empty; after line
//   high, next byte 0x7E received normally.
//  Pop on the cycle a byte is pushed into full FIFO -> count stays 8,
//   overrun 0, oldest byte removed, new byte at tail.
//  UART_RX_PARITY_EN: 0x03 with odd parity bit -> STATUS=0x0000_0008, no push;
//   correct parity -> byte received. Reset mid-frame -> STATUS=0, rx_irq=0.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the memory-mapped UART receiver:
//   - UART_TX_ADDR   : address of the neighbouring TX port
//   - STATUS/DATA register offsets relative to the RX base address
//   - rx_state_t     : receiver FSM state encoding
//   - STATUS register bit positions
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [31:0] UART_TX_ADDR = 32'h0000_1000;

    localparam logic [31:0] STATUS_OFS = 32'h0000_0000;
    localparam logic [31:0] DATA_OFS   = 32'h0000_0004;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_OVERRUN   = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_PARITY    = 3;
    localparam int ST_COUNT     = 8;   // 5-bit field [12:8]

endpackage

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous byte FIFO for received characters.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   push_i, din_i  : write request and byte
//   pop_i          : read request (ignored when empty)
//   head_o         : oldest byte, combinational (undefined when empty)
//   full_o/empty_o : occupancy flags
//   count_o        : current entries, count_next_o : entries after this edge
//   drop_o         : push rejected because FIFO full and no pop this cycle
// A push into a full FIFO is accepted when a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    din_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_next_o,
    output logic          drop_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // When full, the slot being popped is the one the write pointer aims at,
    // so a same-cycle push simply reuses it as the new tail.
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (do_pop && !do_push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign head_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/uart_rx_mmio.sv
// ---------------------------------------------------------------------------
// uart_rx_mmio
// UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with a
// receive FIFO, read through two memory-mapped registers.
// Ports:
//   clk      : clock
//   rst      : asynchronous active-high reset
//   uart_rx  : serial line, idle high, asynchronous to clk
//   rd_addr  : core load address
//   rd_en    : load strobe; qualifies pop and flag-clear side effects
//   rd_data  : combinational read data (0 for unmapped addresses)
//   rx_irq   : registered, high while the FIFO holds data
// Registers:
//   BASE_ADDR   STATUS [0] not_empty [1] overrun [2] frame_err
//                      [3] parity_err [12:8] count; read clears [3:1]
//   BASE_ADDR+4 DATA   [7:0] head byte (0 when empty); read pops
// Macro: UART_RX_PARITY_EN enables the even-parity bit.
// ---------------------------------------------------------------------------
module uart_rx_mmio
    import uart_pkg::*;
#(
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    input  logic [31:0] rd_addr,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic        rx_irq
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] A_STATUS = BASE_ADDR + STATUS_OFS;
    localparam logic [31:0] A_DATA   = BASE_ADDR + DATA_OFS;

    // Line synchronizer plus one history flop for falling-edge detection.
    logic sync1_q, sync2_q, prev_q;
    logic line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign line = sync2_q;

    // Receiver FSM
    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             push, set_frame;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             set_parity;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        push       = 1'b0;
        set_frame  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        set_parity = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (prev_q && !line) begin
                    state_d = START;
                    cnt_d   = CNT_W'(CLK_DIV / 2 - 1);
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    // Mid start bit: still low means a real frame.
                    if (!line) begin
                        state_d = DATA;
                        cnt_d   = CNT_W'(CLK_DIV - 1);
                        bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                        par_bad_d = 1'b0;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shreg_d = {line, shreg_q[7:1]};
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (cnt_q == '0) begin
                    // Even parity: data ones plus parity bit must be even.
                    if ((^shreg_q) ^ line) begin
                        set_parity = 1'b1;
                        par_bad_d  = 1'b1;
                    end
                    state_d = STOP;
                    cnt_d   = CNT_W'(CLK_DIV - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (cnt_q == '0) begin
                    if (!line) begin
                        set_frame = 1'b1;
                        state_d   = WAIT_IDLE;
                    end else begin
`ifdef UART_RX_PARITY_EN
                        push = !par_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (line) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO and register interface
    logic [7:0]    fifo_head;
    logic          fifo_full, fifo_empty, fifo_drop;
    logic [CW-1:0] fifo_count, fifo_count_next;
    logic          pop, stat_rd;

    assign pop     = rd_en && (rd_addr == A_DATA);
    assign stat_rd = rd_en && (rd_addr == A_STATUS);

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .din_i        (shreg_q),
        .pop_i        (pop),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next),
        .drop_o       (fifo_drop)
    );

    // Sticky flags: a set in the same cycle as a STATUS read wins.
    logic overrun_q, overrun_d, frame_q, frame_d, parity_flag, irq_q;
`ifdef UART_RX_PARITY_EN
    logic parity_q, parity_d;
    assign parity_d    = (parity_q && !stat_rd) || set_parity;
    assign parity_flag = parity_q;
`else
    assign parity_flag = 1'b0;
`endif
    assign overrun_d = (overrun_q && !stat_rd) || fifo_drop;
    assign frame_d   = (frame_q && !stat_rd) || set_frame;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
            irq_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
            irq_q     <= (fifo_count_next != '0);
`ifdef UART_RX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign rx_irq = irq_q;

    logic [31:0] status;
    always_comb begin
        status                  = '0;
        status[ST_NOT_EMPTY]    = !fifo_empty;
        status[ST_OVERRUN]      = overrun_q;
        status[ST_FRAME_ERR]    = frame_q;
        status[ST_PARITY]       = parity_flag;
        status[ST_COUNT +: 5]   = 5'(fifo_count);
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr == A_STATUS)
            rd_data = status;
        else if (rd_addr == A_DATA && !fifo_empty)
            rd_data = {24'h0, fifo_head};
    end

    // Full flag is observable only through count; keep it referenced.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx_mmio.sv
module tb_uart_rx_mmio;

    localparam logic [31:0] A_ST = 32'h0000_1004;
    localparam logic [31:0] A_DT = 32'h0000_1008;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // Start bit driven at negedge N0; stop-bit sample (push) at posedge P155
    // for 8N1, one bit time later with parity.
    localparam int PUSH_AT = 155 + 16 * PAR;

    logic        clk = 1'b0;
    logic        rst;
    logic        uart_rx;
    logic [31:0] rd_addr;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rx_irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_rx_mmio #(.CLK_DIV(16), .FIFO_DEPTH(8), .BASE_ADDR(32'h0000_1004)) dut (
        .clk     (clk),
        .rst     (rst),
        .uart_rx (uart_rx),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .rx_irq  (rx_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        uart_rx = v;
        repeat (16) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop_v, input logic bad_par);
        @(negedge clk);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_time((^b) ^ bad_par);
`else
        if (bad_par) uart_rx = 1'b1;
`endif
        bit_time(stop_v);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        rd_addr = a;
        rd_en   = 1'b1;
        #1 d = rd_data;
        @(negedge clk);
        rd_en   = 1'b0;
        rd_addr = '0;
    endtask

    logic [31:0] v;
    logic [31:0] popped;
    int          lat;

    initial begin
        rst = 1'b1; uart_rx = 1'b1; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(negedge clk);
        rd_addr = A_ST;
        #1 chk("reset_status", rd_data, 32'h0);
        chk("reset_irq", {31'h0, rx_irq}, 32'h0);
        rd_addr = '0;
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Single byte 0xA5, with latency from start edge to rx_irq
        lat = -1;
        fork
            send(8'hA5, 1'b1, 1'b0);
            begin
                @(negedge clk);
                for (int k = 1; k <= 250; k++) begin
                    @(negedge clk);
                    if (rx_irq && lat < 0) lat = k;
                end
            end
        join
        chk("a5_latency_window", {31'h0, (lat >= PUSH_AT - 5 && lat <= PUSH_AT + 3)}, 32'h1);
        chk("a5_irq", {31'h0, rx_irq}, 32'h1);
        rd(A_ST, v); chk("a5_status", v, 32'h0000_0101);
        rd(A_DT, v); chk("a5_data", v, 32'h0000_00A5);
        rd(A_ST, v); chk("a5_status_after", v, 32'h0);
        chk("a5_irq_after", {31'h0, rx_irq}, 32'h0);

        // 5-cycle glitch on the idle line
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        rd(A_ST, v); chk("glitch_status", v, 32'h0);
        chk("glitch_irq", {31'h0, rx_irq}, 32'h0);
        rd(A_DT, v); chk("glitch_data_empty", v, 32'h0);

        // Nine bytes, FIFO of eight -> overrun
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("ovr_irq", {31'h0, rx_irq}, 32'h1);
        rd(A_ST, v); chk("ovr_status", v, 32'h0000_0803);
        rd(A_ST, v); chk("ovr_status_cleared", v, 32'h0000_0801);
        for (int i = 1; i <= 8; i++) begin
            rd(A_DT, v); chk("ovr_pop", v, 32'(i));
        end
        rd(A_ST, v); chk("ovr_drained", v, 32'h0);

        // Framing error on 0x3C, then normal 0x7E
        send(8'h3C, 1'b0, 1'b0);
        repeat (16) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        rd(A_ST, v); chk("frame_status", v, 32'h0000_0004);
        chk("frame_irq", {31'h0, rx_irq}, 32'h0);
        rd(A_ST, v); chk("frame_cleared", v, 32'h0);
        send(8'h7E, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        rd(A_ST, v); chk("after_frame_status", v, 32'h0000_0100 | 32'h1);
        rd(A_DT, v); chk("after_frame_data", v, 32'h0000_007E);

        // Pop on the same cycle a byte is pushed into a full FIFO
        for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b1, 1'b0);
        rd(A_ST, v); chk("full_status", v, 32'h0000_0801);
        popped = '0;
        fork
            send(8'h18, 1'b1, 1'b0);
            begin
                @(negedge clk);
                repeat (PUSH_AT - 1) @(negedge clk);
                rd_addr = A_DT;
                rd_en   = 1'b1;
                #1 popped = rd_data;
                @(negedge clk);
                rd_en   = 1'b0;
                rd_addr = '0;
            end
        join
        repeat (10) @(negedge clk);
        chk("pushpop_popped", popped, 32'h0000_0010);
        rd(A_ST, v); chk("pushpop_status", v, 32'h0000_0801);
        for (int i = 1; i <= 8; i++) begin
            rd(A_DT, v); chk("pushpop_pop", v, 32'h10 + 32'(i));
        end
        rd(A_ST, v); chk("pushpop_drained", v, 32'h0);

`ifdef UART_RX_PARITY_EN
        // 0x03 has two ones: even parity bit 0; send 1 instead
        send(8'h03, 1'b1, 1'b1);
        repeat (10) @(negedge clk);
        rd(A_ST, v); chk("par_bad_status", v, 32'h0000_0008);
        chk("par_bad_irq", {31'h0, rx_irq}, 32'h0);
        rd(A_ST, v); chk("par_cleared", v, 32'h0);
        send(8'h03, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        rd(A_ST, v); chk("par_good_status", v, 32'h0000_0101);
        rd(A_DT, v); chk("par_good_data", v, 32'h0000_0003);
`endif

        // Reset in the middle of a frame with data already queued
        send(8'h55, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        chk("prerst_irq", {31'h0, rx_irq}, 32'h1);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (40) @(negedge clk);
        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (200) @(negedge clk);
        rd(A_ST, v); chk("rst_mid_status", v, 32'h0);
        chk("rst_mid_irq", {31'h0, rx_irq}, 32'h0);
        rd(A_DT, v); chk("rst_mid_data", v, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
